// File: rtl/uarc_pkg.sv
// Shared types for the UARC transmit engine: bus operation codes and sender FSM states.
package uarc_pkg;

  typedef enum logic [1:0] {
    UARC_KILL   = 2'd0,
    UARC_INCEPT = 2'd1,
    UARC_SEND   = 2'd2,
    UARC_STREAM = 2'd3
  } uarc_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/uarc_sender_if.sv
// Core command handshake plus the global_* / per-bus lines of the UARC sender.
interface uarc_sender_if #(
  parameter int WORD_MAG    = 5,
  parameter int TOTAL_BUSES = 1
) ();
  import uarc_pkg::*;
  localparam int W = 1 << WORD_MAG;

  logic                   cmd_valid, cmd_ready, cmd_last;
  uarc_op_t               cmd_op;
  logic [TOTAL_BUSES-1:0] cmd_mask;
  logic [W-1:0]           cmd_data, cmd_self_perm, cmd_self_addr, cmd_incept_perm, cmd_incept_addr;
  logic                   abort, done, aborted;
  logic                   global_kill, global_incept, global_send, global_stream;
  logic [W-1:0]           global_data, global_self_permission, global_self_address;
  logic [W-1:0]           global_incept_permission, global_incept_address;
  logic [TOTAL_BUSES-1:0] sender_enables;
  logic [TOTAL_BUSES-1:0] sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks;

  modport master (
    input  cmd_valid, cmd_op, cmd_last, cmd_mask, cmd_data, cmd_self_perm, cmd_self_addr,
           cmd_incept_perm, cmd_incept_addr, abort,
           sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks,
    output cmd_ready, done, aborted, global_kill, global_incept, global_send, global_stream,
           global_data, global_self_permission, global_self_address,
           global_incept_permission, global_incept_address, sender_enables
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_last, cmd_mask, cmd_data, cmd_self_perm, cmd_self_addr,
           cmd_incept_perm, cmd_incept_addr, abort,
           sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks,
    input  cmd_ready, done, aborted, global_kill, global_incept, global_send, global_stream,
           global_data, global_self_permission, global_self_address,
           global_incept_permission, global_incept_address, sender_enables
  );
endinterface

// File: rtl/uarc_ack_collector.sv
// Tracks which selected buses still owe an ack for the in-flight word.
module uarc_ack_collector
  import uarc_pkg::*;
#(
  parameter int TOTAL_BUSES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic [TOTAL_BUSES-1:0] load_mask_i,
  input  logic                   active_i,
  input  uarc_op_t               op_i,
  input  logic [TOTAL_BUSES-1:0] mask_i,
  input  logic [TOTAL_BUSES-1:0] kill_acks_i,
  input  logic [TOTAL_BUSES-1:0] incept_acks_i,
  input  logic [TOTAL_BUSES-1:0] send_acks_i,
  input  logic [TOTAL_BUSES-1:0] stream_acks_i,
  output logic                   all_acked_o
);
  logic [TOTAL_BUSES-1:0] pending_q, pending_d, ack_raw, ack_sel;

  always_comb begin
    ack_raw = '0;
    case (op_i)
      UARC_KILL:   ack_raw = kill_acks_i;
      UARC_INCEPT: ack_raw = incept_acks_i;
      UARC_SEND:   ack_raw = send_acks_i;
      UARC_STREAM: ack_raw = stream_acks_i;
    endcase
  end

  assign ack_sel     = ack_raw & mask_i;
  // An ack arriving in the same cycle as the last outstanding bit retires the word.
  assign all_acked_o = active_i & ~|(pending_q & ~ack_sel);

  always_comb begin
    pending_d = pending_q;
    if (load_i)        pending_d = load_mask_i;
    else if (active_i) pending_d = pending_q & ~ack_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end
endmodule

// File: rtl/uarc_sender.sv
// UARC transmit engine: launches one word per accepted command and retires it
// once every selected bus has acked (or on abort).
module uarc_sender
  import uarc_pkg::*;
#(
  parameter int WORD_MAG    = 5,
  parameter int TOTAL_BUSES = 1
) (
  input logic           clk,
  input logic           reset,
  uarc_sender_if.master sif
);
  localparam int W = 1 << WORD_MAG;

  state_t                 state_q, state_d;
  uarc_op_t               op_q;
  logic                   last_q;
  logic [TOTAL_BUSES-1:0] mask_q;
  logic [W-1:0]           data_q, sperm_q, saddr_q, iperm_q, iaddr_q;
  logic                   stream_open_q, stream_open_d, relaunch_q, relaunch_d;
  logic                   done_q, done_d, aborted_q, aborted_d;
  logic                   accept, load, stream_break, active, all_acked;

  assign active       = (state_q == ACTIVE);
  assign accept       = sif.cmd_valid & sif.cmd_ready;
  assign load         = accept & (|sif.cmd_mask);
  assign stream_break = stream_open_q &
                        ~((sif.cmd_op == UARC_STREAM) & (sif.cmd_mask == mask_q));

  always_comb begin
    state_d       = state_q;
    stream_open_d = stream_open_q;
    relaunch_d    = 1'b0;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (stream_break) stream_open_d = 1'b0;
        if (!load) begin
          done_d = 1'b1;
        end else if (stream_break) begin
          // Pass through GAP first so the old stream's enables fall before the new request.
          state_d    = GAP;
          relaunch_d = 1'b1;
        end else begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (all_acked) begin
          state_d       = GAP;
          done_d        = 1'b1;
          stream_open_d = (op_q == UARC_STREAM) & ~last_q;
        end else if (sif.abort) begin
          state_d       = GAP;
          done_d        = 1'b1;
          aborted_d     = 1'b1;
          stream_open_d = 1'b0;
        end
      end
      GAP:     state_d = relaunch_q ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= UARC_KILL;
      last_q        <= 1'b0;
      mask_q        <= '0;
      data_q        <= '0;
      sperm_q       <= '0;
      saddr_q       <= '0;
      iperm_q       <= '0;
      iaddr_q       <= '0;
      stream_open_q <= 1'b0;
      relaunch_q    <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      stream_open_q <= stream_open_d;
      relaunch_q    <= relaunch_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      if (load) begin
        op_q    <= sif.cmd_op;
        last_q  <= sif.cmd_last;
        mask_q  <= sif.cmd_mask;
        data_q  <= sif.cmd_data;
        sperm_q <= sif.cmd_self_perm;
        saddr_q <= sif.cmd_self_addr;
        iperm_q <= sif.cmd_incept_perm;
        iaddr_q <= sif.cmd_incept_addr;
      end
    end
  end

  uarc_ack_collector #(.TOTAL_BUSES(TOTAL_BUSES)) u_acks (
    .clk           (clk),
    .reset         (reset),
    .load_i        (load),
    .load_mask_i   (sif.cmd_mask),
    .active_i      (active),
    .op_i          (op_q),
    .mask_i        (mask_q),
    .kill_acks_i   (sif.sender_kill_acks),
    .incept_acks_i (sif.sender_incept_acks),
    .send_acks_i   (sif.sender_send_acks),
    .stream_acks_i (sif.sender_stream_acks),
    .all_acked_o   (all_acked)
  );

  assign sif.cmd_ready     = (state_q == IDLE);
  assign sif.done          = done_q;
  assign sif.aborted       = aborted_q;
  assign sif.global_kill   = active & (op_q == UARC_KILL);
  assign sif.global_incept = active & (op_q == UARC_INCEPT);
  assign sif.global_send   = active & (op_q == UARC_SEND);
  assign sif.global_stream = active & (op_q == UARC_STREAM);
  // Enables stay up across GAP/IDLE while a stream is open.
  assign sif.sender_enables = (active | stream_open_q) ? mask_q : '0;
  assign sif.global_data              = data_q;
  assign sif.global_self_permission   = sperm_q;
  assign sif.global_self_address      = saddr_q;
  assign sif.global_incept_permission = iperm_q;
  assign sif.global_incept_address    = iaddr_q;
endmodule

// File: tb/tb_uarc_sender.sv
// Bench for uarc_sender: directed vector table, randomized words against a
// word-level timing model, and a reset-mid-transfer sequence.
module tb_uarc_sender;
  import uarc_pkg::*;

  localparam int WM = 5;
  localparam int TB = 4;
  localparam int W  = 32;
  localparam int NV = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uarc_sender_if #(.WORD_MAG(WM), .TOTAL_BUSES(TB)) u ();
  uarc_sender #(.WORD_MAG(WM), .TOTAL_BUSES(TB)) dut (.clk(clk), .reset(reset), .sif(u));

  int n_vec = 0;
  int n_err = 0;
  bit m_open = 1'b0;
  logic [TB-1:0] m_mask = '0;

  typedef struct {
    uarc_op_t             op;
    logic [TB-1:0]        mask;
    bit                   last;
    logic [TB-1:0][15:0]  ack;
    int                   abort_at;
    bit                   noisy;
    int                   exp_lat;
    bit                   exp_ab;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {u.global_stream, u.global_send, u.global_incept, u.global_kill};
  endfunction

  function automatic logic [TB-1:0][15:0] mk(input int a0, input int a1, input int a2, input int a3);
    logic [TB-1:0][15:0] r;
    r[0] = a0[15:0]; r[1] = a1[15:0]; r[2] = a2[15:0]; r[3] = a3[15:0];
    return r;
  endfunction

  task automatic zero_inputs();
    u.cmd_valid = 1'b0; u.abort = 1'b0;
    u.sender_kill_acks = '0; u.sender_incept_acks = '0;
    u.sender_send_acks = '0; u.sender_stream_acks = '0;
  endtask

  // Word-level model: request appears one cycle after accept (two if an open
  // stream must close first), lasts until the last selected bus acks or abort,
  // done one cycle later. Acks are driven per bus at chosen offsets.
  task automatic run_word(input uarc_op_t op, input logic [TB-1:0] mask, input bit last,
                          input logic [TB-1:0][15:0] ack_at, input int abort_at, input bit noisy,
                          output int lat, output bit ab, output int exp_lat, output bit exp_ab);
    logic [W-1:0]  pl [5];
    logic [TB-1:0] av [4];
    logic [TB-1:0] en_after;
    int d, fin, end_k, k;
    bit new_open;
    for (int i = 0; i < 5; i++) pl[i] = $urandom;
    d   = (m_open && !(op == UARC_STREAM && mask == m_mask)) ? 1 : 0;
    fin = 0;
    for (int b = 0; b < TB; b++)
      if (mask[b] && int'(ack_at[b]) > fin) fin = int'(ack_at[b]);
    exp_ab   = (mask != '0) && (abort_at < fin);
    end_k    = exp_ab ? abort_at : fin;
    exp_lat  = (mask == '0) ? 1 : 2 + d + end_k;
    new_open = (op == UARC_STREAM) && !last && !exp_ab && (mask != '0);
    en_after = new_open ? mask : '0;
    lat = -1; ab = 1'b0;

    chk("ready_before_accept", u.cmd_ready, 1'b1);
    u.cmd_valid = 1'b1; u.cmd_op = op; u.cmd_last = last; u.cmd_mask = mask;
    u.cmd_data = pl[0]; u.cmd_self_perm = pl[1]; u.cmd_self_addr = pl[2];
    u.cmd_incept_perm = pl[3]; u.cmd_incept_addr = pl[4];
    @(negedge clk);
    u.cmd_valid = 1'b0; u.cmd_data = $urandom; u.cmd_self_perm = $urandom;
    u.cmd_self_addr = $urandom; u.cmd_incept_perm = $urandom; u.cmd_incept_addr = $urandom;
    u.cmd_mask = TB'($urandom); u.cmd_op = uarc_op_t'($urandom_range(3, 0));

    for (int t = 1; t <= 64 && lat < 0; t++) begin
      k = t - 1 - d;
      if (u.done) begin
        lat = t; ab = u.aborted;
        chk("retire_strobes", strobes(), 4'b0);
        chk("retire_enables", u.sender_enables, en_after);
        chk("retire_ready", u.cmd_ready, mask == '0);
      end else begin
        if (k < 0) begin
          chk("close_strobes", strobes(), 4'b0);
          chk("close_enables", u.sender_enables, '0);
        end else if (k <= end_k) begin
          chk("active_strobe", strobes(), 4'b0001 << int'(op));
          chk("active_enables", u.sender_enables, mask);
          chk("active_ready", u.cmd_ready, 1'b0);
          chk("active_data", u.global_data, pl[0]);
          chk("active_sperm", u.global_self_permission, pl[1]);
          chk("active_saddr", u.global_self_address, pl[2]);
          chk("active_iperm", u.global_incept_permission, pl[3]);
          chk("active_iaddr", u.global_incept_address, pl[4]);
        end
        for (int o = 0; o < 4; o++) av[o] = noisy ? '1 : TB'($urandom);
        if (k >= 0)
          for (int b = 0; b < TB; b++)
            if (mask[b])
              av[int'(op)][b] = (k == int'(ack_at[b])) ||
                                (k > int'(ack_at[b]) && (noisy || $urandom_range(1, 0) == 1));
        u.sender_kill_acks = av[0]; u.sender_incept_acks = av[1];
        u.sender_send_acks = av[2]; u.sender_stream_acks = av[3];
        u.abort = (k == abort_at) && (mask != '0);
        @(negedge clk);
      end
    end
    zero_inputs();
    if (lat > 0 && mask != '0) begin
      @(negedge clk);
      chk("idle_ready", u.cmd_ready, 1'b1);
      chk("idle_done", u.done, 1'b0);
      chk("idle_enables", u.sender_enables, en_after);
    end
    m_open = new_open;
    if (new_open) m_mask = mask;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[18];
    int lat, el;
    bit ab, ea;
    uarc_op_t rop;
    logic [TB-1:0] rmask;
    logic [TB-1:0][15:0] racks;
    int rabort;
    bit any_never;

    tbl[0]  = '{UARC_SEND,   4'b0101, 1'b0, mk(0, NV, 2, NV),   NV, 1'b0, 4, 1'b0};
    tbl[1]  = '{UARC_KILL,   4'b0011, 1'b0, mk(4, 4, NV, NV),   NV, 1'b1, 6, 1'b0};
    tbl[2]  = '{UARC_STREAM, 4'b1000, 1'b0, mk(NV, NV, NV, 0),  NV, 1'b0, 2, 1'b0};
    tbl[3]  = '{UARC_STREAM, 4'b1000, 1'b0, mk(NV, NV, NV, 0),  NV, 1'b0, 2, 1'b0};
    tbl[4]  = '{UARC_STREAM, 4'b1000, 1'b1, mk(NV, NV, NV, 0),  NV, 1'b0, 2, 1'b0};
    tbl[5]  = '{UARC_INCEPT, 4'b0000, 1'b0, mk(NV, NV, NV, NV), NV, 1'b0, 1, 1'b0};
    tbl[6]  = '{UARC_SEND,   4'b0001, 1'b0, mk(NV, NV, NV, NV), 4,  1'b0, 6, 1'b1};
    tbl[7]  = '{UARC_SEND,   4'b0010, 1'b0, mk(NV, 2, NV, NV),  2,  1'b0, 4, 1'b0};
    tbl[8]  = '{UARC_STREAM, 4'b0110, 1'b0, mk(NV, 1, 0, NV),   NV, 1'b0, 3, 1'b0};
    tbl[9]  = '{UARC_SEND,   4'b0001, 1'b0, mk(0, NV, NV, NV),  NV, 1'b0, 3, 1'b0};
    tbl[10] = '{UARC_STREAM, 4'b0100, 1'b0, mk(NV, NV, 0, NV),  NV, 1'b0, 2, 1'b0};
    tbl[11] = '{UARC_STREAM, 4'b0100, 1'b0, mk(NV, NV, NV, NV), 1,  1'b0, 3, 1'b1};
    tbl[12] = '{UARC_KILL,   4'b1111, 1'b0, mk(0, 0, 0, 0),     NV, 1'b0, 2, 1'b0};
    tbl[13] = '{UARC_STREAM, 4'b0011, 1'b0, mk(0, 0, NV, NV),   NV, 1'b0, 2, 1'b0};
    tbl[14] = '{UARC_INCEPT, 4'b0000, 1'b0, mk(NV, NV, NV, NV), NV, 1'b0, 1, 1'b0};
    tbl[15] = '{UARC_INCEPT, 4'b1001, 1'b0, mk(3, NV, NV, 1),   NV, 1'b0, 5, 1'b0};
    tbl[16] = '{UARC_STREAM, 4'b1111, 1'b0, mk(0, 0, 0, 0),     NV, 1'b1, 2, 1'b0};
    tbl[17] = '{UARC_STREAM, 4'b0111, 1'b1, mk(0, 0, 0, NV),    NV, 1'b0, 3, 1'b0};

    zero_inputs();
    u.cmd_op = UARC_KILL; u.cmd_last = 1'b0; u.cmd_mask = '0;
    u.cmd_data = '0; u.cmd_self_perm = '0; u.cmd_self_addr = '0;
    u.cmd_incept_perm = '0; u.cmd_incept_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", u.cmd_ready, 1'b1);
    chk("reset_done", {u.done, u.aborted}, 2'b00);
    chk("reset_strobes", strobes(), 4'b0);
    chk("reset_enables", u.sender_enables, '0);
    chk("reset_payload", {u.global_data, u.global_incept_address}, 64'h0);

    for (int i = 0; i < 18; i++) begin
      run_word(tbl[i].op, tbl[i].mask, tbl[i].last, tbl[i].ack, tbl[i].abort_at, tbl[i].noisy,
               lat, ab, el, ea);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_aborted", i), ab, tbl[i].exp_ab);
    end

    for (int n = 0; n < 160; n++) begin
      rop   = uarc_op_t'($urandom_range(3, 0));
      rmask = ($urandom_range(9, 0) == 0) ? '0 : TB'($urandom);
      if (m_open && $urandom_range(9, 0) < 7) begin
        rop = UARC_STREAM; rmask = m_mask;
      end
      any_never = 1'b0;
      for (int b = 0; b < TB; b++) begin
        racks[b] = ($urandom_range(7, 0) == 0) ? 16'(NV) : 16'($urandom_range(5, 0));
        if (rmask[b] && racks[b] == 16'(NV)) any_never = 1'b1;
      end
      rabort = ($urandom_range(3, 0) == 0 || any_never) ? $urandom_range(6, 0) : NV;
      run_word(rop, rmask, $urandom_range(1, 0) == 1, racks, rabort, $urandom_range(4, 0) == 0,
               lat, ab, el, ea);
      chk("rand_latency", lat, el);
      chk("rand_aborted", ab, ea);
    end

    // Reset while a SEND is waiting for acks.
    run_word(UARC_INCEPT, '0, 1'b0, mk(NV, NV, NV, NV), NV, 1'b0, lat, ab, el, ea);
    chk("pre_reset_latency", lat, el);
    u.cmd_valid = 1'b1; u.cmd_op = UARC_SEND; u.cmd_mask = 4'b0011; u.cmd_data = 32'hDEADBEEF;
    @(negedge clk);
    u.cmd_valid = 1'b0;
    chk("rst_active_strobe", strobes(), 4'b0100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_strobes", strobes(), 4'b0);
    chk("rst_enables", u.sender_enables, '0);
    chk("rst_done", {u.done, u.aborted}, 2'b00);
    chk("rst_data", u.global_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after_ready", u.cmd_ready, 1'b1);
    chk("rst_after_done", u.done, 1'b0);
    m_open = 1'b0;
    run_word(UARC_SEND, 4'b0011, 1'b0, mk(0, 1, NV, NV), NV, 1'b0, lat, ab, el, ea);
    chk("post_reset_latency", lat, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
